insight_commit_trace_buffer: RTL and testbench

Captures the per-cycle retirement stream of hart 0 from the Insight core commit signals and buffers it in a FIFO. It emits typed trace packets to a downstream trace sink over a valid/ready handshake. It sits directly downstream of the hart-0 Insight tile observation point. Commits that arrive while the FIFO is full are counted and replaced by a single DROP marker packet, so the sink always knows that retirements were lost.

---
 rtl/insight_trace_pkg.sv | 18 +
 rtl/insight_trace_fifo.sv | 45 ++++
 rtl/insight_commit_trace_buffer.sv | 85 ++++++++
 tb/tb_insight_commit_trace_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/insight_trace_pkg.sv
// insight_trace_pkg: shared types and default sizes for the hart-0 commit trace buffer.
package insight_trace_pkg;
    localparam int DEPTH = 16;
    localparam int PC_W  = 39;
    localparam int TS_W  = 16;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {COMMIT = 2'd0, EXCEPTION = 2'd1, DROP = 2'd2} pkt_type_e;

    typedef struct packed {
        pkt_type_e         kind;
        logic [TS_W-1:0]   ts;
        logic [PC_W-1:0]   pc;
        logic [31:0]       payload;
    } pkt_t;

    typedef enum logic {NORMAL = 1'b0, DROPPING = 1'b1} state_e;
endpackage

// File: rtl/insight_trace_fifo.sv
// insight_trace_fifo: synchronous pkt_t FIFO; full/empty come from the registered level,
// so a same-cycle pop never makes room for a same-cycle write.
module insight_trace_fifo
    import insight_trace_pkg::*;
#(
    parameter int DEPTH = insight_trace_pkg::DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_wr_en,
    input  pkt_t          i_wr_data,
    input  logic          i_rd_en,
    output pkt_t          o_rd_data,
    output logic [AW:0]   o_level,
    output logic          o_full,
    output logic          o_empty
);
    pkt_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_level;
    logic          w_wr, w_rd;

    assign o_full    = r_level == (AW+1)'(DEPTH);
    assign o_empty   = r_level == '0;
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_level   = r_level;
    // Masking the head keeps the output all-zero after reset without resetting storage.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clock)
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd);
            r_level  <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
endmodule

// File: rtl/insight_commit_trace_buffer.sv
// insight_commit_trace_buffer: timestamps hart-0 retirements into trace packets and
// replaces commits lost to a full FIFO with one DROP marker per overflow episode.
module insight_commit_trace_buffer
    import insight_trace_pkg::*;
#(
    parameter int DEPTH = insight_trace_pkg::DEPTH,
    parameter int CNT_W = insight_trace_pkg::CNT_W
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_commit_valid,
    input  logic [PC_W-1:0]           i_commit_pc,
    input  logic [31:0]               i_commit_insn,
    input  logic                      i_commit_exception,
    input  logic [7:0]                i_commit_cause,
    output logic                      o_trace_valid,
    input  logic                      i_trace_ready,
    output pkt_t                      o_trace_pkt,
    output logic [CNT_W-1:0]          o_drop_total,
    output logic [$clog2(DEPTH):0]    o_fifo_level
);
    state_e           r_state, w_state_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_drop_cnt, w_drop_cnt_nxt, w_cnt_inc, r_drop_total;
    logic             w_full, w_empty, w_push, w_drop;
    pkt_t             w_pkt;

    assign w_cnt_inc     = (r_drop_cnt == '1) ? r_drop_cnt : r_drop_cnt + 1'b1;
    assign o_trace_valid = ~w_empty;
    assign o_drop_total  = r_drop_total;

    always_comb begin
        w_state_nxt    = r_state;
        w_drop_cnt_nxt = r_drop_cnt;
        w_push         = 1'b0;
        w_drop         = 1'b0;
        w_pkt          = '{kind: i_commit_exception ? EXCEPTION : COMMIT, ts: r_ts, pc: i_commit_pc,
                           payload: i_commit_exception ? {24'b0, i_commit_cause} : i_commit_insn};
        if (r_state == NORMAL) begin
            w_push = i_commit_valid & ~w_full;
            w_drop = i_commit_valid & w_full;
            if (w_drop) begin
                w_drop_cnt_nxt = CNT_W'(1);
                w_state_nxt    = DROPPING;
            end
        end else begin
            // Any commit seen while dropping is lost, including one in the marker cycle.
            w_drop = i_commit_valid;
            if (w_full) begin
                w_drop_cnt_nxt = i_commit_valid ? w_cnt_inc : r_drop_cnt;
            end else begin
                w_push         = 1'b1;
                w_pkt          = '{kind: DROP, ts: r_ts, pc: '0,
                                   payload: 32'(i_commit_valid ? w_cnt_inc : r_drop_cnt)};
                w_drop_cnt_nxt = '0;
                w_state_nxt    = NORMAL;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            r_state      <= NORMAL;
            r_ts         <= '0;
            r_drop_cnt   <= '0;
            r_drop_total <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ts         <= r_ts + 1'b1;
            r_drop_cnt   <= w_drop_cnt_nxt;
            r_drop_total <= (w_drop && r_drop_total != '1) ? r_drop_total + 1'b1 : r_drop_total;
        end

    insight_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (w_push),
        .i_wr_data (w_pkt),
        .i_rd_en   (o_trace_valid & i_trace_ready),
        .o_rd_data (o_trace_pkt),
        .o_level   (o_fifo_level),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );
endmodule

// File: tb/tb_insight_commit_trace_buffer.sv
// tb_insight_commit_trace_buffer: directed vectors plus overflow, marker, saturation,
// mid-episode reset and timestamp-wrap sequences; a CNT_W=4 copy shares the stimulus.
module tb_insight_commit_trace_buffer;
    import insight_trace_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, cv = 1'b0, exc = 1'b0, rdy = 1'b0;
    logic [38:0] pc = '0;
    logic [31:0] insn = '0;
    logic [7:0]  cause = '0;
    logic        tv, tv4;
    pkt_t        pkt, pkt4;
    logic [15:0] dt;
    logic [3:0]  dt4;
    logic [4:0]  lvl, lvl4;
    logic [15:0] cyc;
    int          n_chk = 0, n_fail = 0;
    bit          sat = 1'b0;
    pkt_t        exp_q[$];

    typedef struct {
        logic [38:0] pc;
        logic [31:0] insn;
        logic        exc;
        logic [7:0]  cause;
        pkt_type_e   kind;
        logic [31:0] payload;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) cyc <= rst ? 16'd0 : cyc + 16'd1;

    insight_commit_trace_buffer dut (
        .i_clock(clk), .i_reset(rst), .i_commit_valid(cv), .i_commit_pc(pc),
        .i_commit_insn(insn), .i_commit_exception(exc), .i_commit_cause(cause),
        .o_trace_valid(tv), .i_trace_ready(rdy), .o_trace_pkt(pkt),
        .o_drop_total(dt), .o_fifo_level(lvl));

    insight_commit_trace_buffer #(.CNT_W(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_commit_valid(cv), .i_commit_pc(pc),
        .i_commit_insn(insn), .i_commit_exception(exc), .i_commit_cause(cause),
        .o_trace_valid(tv4), .i_trace_ready(rdy), .o_trace_pkt(pkt4),
        .o_drop_total(dt4), .o_fifo_level(lvl4));

    function automatic pkt_t mk(pkt_type_e k, logic [15:0] t, logic [38:0] p, logic [31:0] d);
        mk = '{kind: k, ts: t, pc: p, payload: d};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; cv = 1'b0; rdy = 1'b0; exc = 1'b0; cause = '0;
        #1;
        chk("reset valid", tv, 0);
        chk("reset level", lvl, 0);
        chk("reset drop_total", dt, 0);
        chk("reset pkt", pkt, 0);
        step;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill(input int n, input logic [38:0] base);
        for (int i = 0; i < n; i++) begin
            cv = 1'b1; exc = 1'b0; pc = base + 39'(4 * i); insn = 32'h13 + 32'(i << 7);
            exp_q.push_back(mk(COMMIT, cyc, pc, insn));
            step;
        end
        cv = 1'b0;
    endtask

    task automatic drops(input int n, input logic [38:0] base);
        for (int i = 0; i < n; i++) begin
            cv = 1'b1; exc = 1'b0; pc = base + 39'(4 * i); insn = 32'hBAD0 + 32'(i);
            step;
        end
        cv = 1'b0;
    endtask

    task automatic release_one;
        chk("head stable", pkt, exp_q[0]);
        rdy = 1'b1;
        step;
        rdy = 1'b0;
        void'(exp_q.pop_front());
        chk("level after pop", lvl, 15);
    endtask

    task automatic drain(input int budget);
        pkt_t e;
        int   c = 0;
        rdy = 1'b1;
        while (exp_q.size() > 0 && c < budget) begin
            if (tv) begin
                e = exp_q.pop_front();
                chk("drain pkt", pkt, e);
                if (sat && e.kind == DROP) chk("sat4 drop payload", pkt4.payload, 15);
            end
            step;
            c++;
        end
        if (exp_q.size() != 0) chk("drain timeout", exp_q.size(), 0);
        chk("drain empty", tv, 0);
        rdy = 1'b0;
    endtask

    initial begin
        int n;
        vecs[0] = '{39'h80000000, 32'h00000013, 1'b0, 8'h00, COMMIT, 32'h00000013};
        vecs[1] = '{39'h80000004, 32'h00000073, 1'b1, 8'h02, EXCEPTION, 32'h00000002};
        vecs[2] = '{39'h7FFFFFFFFC, 32'hFFFFFFFF, 1'b0, 8'h00, COMMIT, 32'hFFFFFFFF};
        vecs[3] = '{39'h00000100, 32'hDEADBEEF, 1'b1, 8'hFF, EXCEPTION, 32'h000000FF};
        vecs[4] = '{39'h12345678, 32'hCAFEF00D, 1'b0, 8'h55, COMMIT, 32'hCAFEF00D};

        do_reset;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [15:0] t;
            cv = 1'b1; pc = vecs[i].pc; insn = vecs[i].insn; exc = vecs[i].exc; cause = vecs[i].cause;
            t = cyc;
            chk("no bypass", tv, 0);
            step;
            cv = 1'b0; exc = 1'b0;
            chk("vec valid", tv, 1);
            chk("vec type", pkt.kind, vecs[i].kind);
            chk("vec ts", pkt.ts, t);
            chk("vec pc", pkt.pc, vecs[i].pc);
            chk("vec payload", pkt.payload, vecs[i].payload);
            chk("vec level", lvl, 1);
            step;
            chk("vec popped", tv, 0);
        end

        // Overflow: 16 fill, 5 dropped, one pop opens a slot for the marker.
        do_reset;
        fill(16, 39'h1000);
        chk("full level", lvl, 16);
        drops(5, 39'h2000);
        chk("ovf level", lvl, 16);
        chk("ovf drop_total", dt, 5);
        release_one;
        exp_q.push_back(mk(DROP, cyc, '0, 32'd5));
        step;
        chk("marker level", lvl, 16);
        chk("ovf drop_total after", dt, 5);
        drain(60);

        // Commit arriving in the marker cycle is folded into the count.
        do_reset;
        fill(16, 39'h4000);
        drops(3, 39'h5000);
        release_one;
        cv = 1'b1; pc = 39'h6000; insn = 32'h0BADC0DE;
        exp_q.push_back(mk(DROP, cyc, '0, 32'd4));
        step;
        cv = 1'b0;
        chk("conc drop_total", dt, 4);
        chk("conc level", lvl, 16);
        drain(60);

        // Saturation on the narrow-counter instance.
        do_reset;
        fill(16, 39'h7000);
        drops(20, 39'h8000);
        chk("sat4 drop_total", dt4, 15);
        release_one;
        exp_q.push_back(mk(DROP, cyc, '0, 32'd20));
        step;
        chk("wide drop_total", dt, 20);
        chk("sat4 drop_total after", dt4, 15);
        sat = 1'b1;
        drain(60);
        sat = 1'b0;

        // Asynchronous reset while dropping.
        do_reset;
        fill(16, 39'h9000);
        drops(2, 39'hA000);
        #2;
        rst = 1'b1;
        #1;
        chk("async valid", tv, 0);
        chk("async level", lvl, 0);
        chk("async drop_total", dt, 0);
        chk("async pkt", pkt, 0);
        step;
        rst = 1'b0;
        exp_q.delete();
        fill(1, 39'hB000);
        drain(10);
        for (int i = 0; i < 20; i++) step;
        chk("post reset no drop", tv, 0);
        chk("post reset drop_total", dt, 0);

        // Timestamp wrap across back-to-back packets.
        do_reset;
        rdy = 1'b1;
        n = 0;
        while (cyc != 16'hFFFF && n < 70000) begin
            step;
            n++;
        end
        chk("wrap reached", cyc, 16'hFFFF);
        cv = 1'b1; pc = 39'hC000; insn = 32'h1;
        step;
        pc = 39'hC004; insn = 32'h2;
        chk("wrap ts ffff", pkt.ts, 16'hFFFF);
        step;
        cv = 1'b0;
        chk("wrap ts 0000", pkt.ts, 16'h0000);
        chk("wrap pc", pkt.pc, 39'hC004);
        step;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
